// File: rtl/entropy_harvester.sv
// Ring-oscillator entropy consumer: sampling, repetition health test,
// pair whitening and a small byte FIFO read by the CPU RNG register.
module entropy_harvester #(
    parameter int SAMPLE_DIV = 16,
    parameter int REP_LIMIT  = 8,
    parameter int FIFO_AW    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] raw_dat,
    input  logic       clr_fail,
    input  logic       rd_req,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       fifo_empty,
    output logic       fifo_full,
    output logic       health_fail,
    output logic [7:0] drop_cnt
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int DW    = $clog2(SAMPLE_DIV);
    localparam int RW    = $clog2(REP_LIMIT);
    localparam int CW    = FIFO_AW + 1;

    localparam logic [DW-1:0] DIV_MAX  = DW'(SAMPLE_DIV - 1);
    localparam logic [DW-1:0] DIV_ONE  = DW'(1);
    localparam logic [RW-1:0] REP_MAX  = RW'(REP_LIMIT - 1);
    localparam logic [RW-1:0] REP_ONE  = RW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);

    typedef enum logic [1:0] {
        FILL_A,
        FILL_B,
        PUSH,
        FAIL
    } state_t;

    function automatic logic [7:0] bitrev(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = v[7-i];
        end
        return r;
    endfunction

    state_t             state;
    logic [DW-1:0]      div_cnt;
    logic               tick;
    logic [7:0]         prev;
    logic               prev_valid;
    logic [RW-1:0]      rep_cnt;
    logic [RW-1:0]      rep_next;
    logic               trip;
    logic [7:0]         samp_a;
    logic [7:0]         white;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [CW-1:0]      count;
    logic [CW-1:0]      cnt_next;
    logic               do_pop;
    logic               do_push;
    logic               do_drop;

    // Tick, health-test lookahead and FIFO operation decode for this clock.
    always_comb begin
        tick     = (div_cnt == DIV_MAX);
        rep_next = '0;
        if (prev_valid && (raw_dat == prev)) begin
            rep_next = (rep_cnt == REP_MAX) ? rep_cnt : rep_cnt + REP_ONE;
        end
        trip    = tick && (state != FAIL) && (rep_next == REP_MAX);
        do_pop  = rd_req && !fifo_empty && !trip;
        do_push = (state == PUSH) && (!fifo_full || do_pop);
        do_drop = (state == PUSH) && fifo_full && !do_pop;
        cnt_next = count;
        if (do_push && !do_pop) begin
            cnt_next = count + CNT_ONE;
        end else if (do_pop && !do_push) begin
            cnt_next = count - CNT_ONE;
        end
    end

    // Free-running sample-rate divider, independent of FSM state.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_ONE;
        end
    end

    // Health test and sample-pair FSM; a trip pre-empts any pending work.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FILL_A;
            prev        <= '0;
            prev_valid  <= 1'b0;
            rep_cnt     <= '0;
            health_fail <= 1'b0;
            samp_a      <= '0;
            white       <= '0;
        end else if (state == FAIL) begin
            if (clr_fail) begin
                health_fail <= 1'b0;
                rep_cnt     <= '0;
                prev_valid  <= 1'b0;
                state       <= FILL_A;
            end else if (tick) begin
                prev       <= raw_dat;
                prev_valid <= 1'b1;
                rep_cnt    <= rep_next;
            end
        end else begin
            if (tick) begin
                prev       <= raw_dat;
                prev_valid <= 1'b1;
                rep_cnt    <= rep_next;
            end
            if (trip) begin
                health_fail <= 1'b1;
                state       <= FAIL;
            end else begin
                case (state)
                    FILL_A: begin
                        if (tick) begin
                            samp_a <= raw_dat;
                            state  <= FILL_B;
                        end
                    end
                    FILL_B: begin
                        if (tick) begin
                            white <= samp_a ^ bitrev(raw_dat);
                            state <= PUSH;
                        end
                    end
                    PUSH: begin
                        state <= FILL_A;
                    end
                    default: begin
                        state <= FILL_A;
                    end
                endcase
            end
        end
    end

    // Circular byte FIFO with registered flags, read port and drop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            fifo_empty <= 1'b1;
            fifo_full  <= 1'b0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            drop_cnt   <= '0;
        end else if (trip) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            fifo_empty <= 1'b1;
            fifo_full  <= 1'b0;
            rd_valid   <= 1'b0;
        end else begin
            rd_valid <= do_pop;
            if (do_pop) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + PTR_ONE;
            end
            if (do_push) begin
                mem[wr_ptr] <= white;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (do_drop && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
            count      <= cnt_next;
            fifo_empty <= (cnt_next == '0);
            fifo_full  <= (cnt_next == CNT_FULL);
        end
    end

endmodule
